// File: rtl/alu_sequencer.sv
// Control sequencer for the external ALU: decodes ALU-group opcodes, drives ALU selects and
// dataflow, owns accumulator A and status register P, and hands RMW results back via valid/ready.
module alu_sequencer #(
    parameter logic [7:0] P_RESET = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [7:0] opcode,
    input  logic [7:0] operand,
    output logic       sum_sel,
    output logic       and_sel,
    output logic       xor_sel,
    output logic       or_sel,
    output logic       asl_sel,
    output logic       lsr_sel,
    output logic       rol_sel,
    output logic       ror_sel,
    output logic       subtract,
    output logic       target_bus,
    output logic       carry_in,
    input  logic [7:0] alu_out,
    input  logic       alu_overflow,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       alu_negative,
    output logic [7:0] a_reg,
    output logic [7:0] p_reg,
    output logic       wb_valid,
    output logic [7:0] wb_data,
    input  logic       wb_ready,
    output logic       done,
    output logic       illegal
);

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    localparam int unsigned SelSum = 7;
    localparam int unsigned SelAnd = 6;
    localparam int unsigned SelXor = 5;
    localparam int unsigned SelOr  = 4;
    localparam int unsigned SelAsl = 3;
    localparam int unsigned SelLsr = 2;
    localparam int unsigned SelRol = 1;
    localparam int unsigned SelRor = 0;

    state_e     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] operand_q, operand_d;
    logic [7:0] a_q, a_d;
    logic [7:0] p_q, p_d;
    logic [7:0] wb_data_q, wb_data_d;
    logic       done_q, done_d;
    logic       illegal_q, illegal_d;

    logic [7:0] dec_sel;
    logic       dec_sub, dec_cin, dec_tbus;
    logic       dec_write_a, dec_rmw, dec_data, dec_illegal;
    logic [7:0] p_next;
    logic       exec;
    logic       sbc_carry;

    assign exec = (state_q == StExec);

    // Carry out of A + ~operand + C, expressed as a compare to avoid an unused 9-bit sum.
    assign sbc_carry = (a_q > operand_q) | ((a_q == operand_q) & p_q[0]);

    always_comb begin
        dec_sel     = '0;
        dec_sub     = 1'b0;
        dec_cin     = 1'b0;
        dec_tbus    = 1'b0;
        dec_write_a = 1'b0;
        dec_rmw     = 1'b0;
        dec_data    = 1'b0;
        dec_illegal = 1'b0;
        p_next      = p_q;
        case (opcode_q)
            8'h69: begin
                dec_sel[SelSum] = 1'b1; dec_cin = p_q[0]; dec_write_a = 1'b1; dec_data = 1'b1;
                p_next[6] = alu_overflow; p_next[0] = alu_carry;
            end
            8'hE9: begin
                dec_sel[SelSum] = 1'b1; dec_sub = 1'b1; dec_cin = p_q[0];
                dec_write_a = 1'b1; dec_data = 1'b1;
                p_next[6] = alu_overflow; p_next[0] = sbc_carry;
            end
            8'h29: begin dec_sel[SelAnd] = 1'b1; dec_write_a = 1'b1; dec_data = 1'b1; end
            8'h09: begin dec_sel[SelOr]  = 1'b1; dec_write_a = 1'b1; dec_data = 1'b1; end
            8'h49: begin dec_sel[SelXor] = 1'b1; dec_write_a = 1'b1; dec_data = 1'b1; end
            8'hC9: begin
                dec_sel[SelSum] = 1'b1; dec_sub = 1'b1; dec_cin = 1'b1; dec_data = 1'b1;
                p_next[0] = (a_q >= operand_q);
            end
            8'h0A: begin
                dec_sel[SelAsl] = 1'b1; dec_write_a = 1'b1; dec_data = 1'b1; p_next[0] = a_q[7];
            end
            8'h4A: begin
                dec_sel[SelLsr] = 1'b1; dec_write_a = 1'b1; dec_data = 1'b1; p_next[0] = a_q[0];
            end
            8'h2A: begin
                dec_sel[SelRol] = 1'b1; dec_cin = p_q[0]; dec_write_a = 1'b1; dec_data = 1'b1;
                p_next[0] = a_q[7];
            end
            8'h6A: begin
                dec_sel[SelRor] = 1'b1; dec_cin = p_q[0]; dec_write_a = 1'b1; dec_data = 1'b1;
                p_next[0] = a_q[0];
            end
            8'h06: begin
                dec_sel[SelAsl] = 1'b1; dec_tbus = 1'b1; dec_rmw = 1'b1; dec_data = 1'b1;
                p_next[0] = operand_q[7];
            end
            8'h46: begin
                dec_sel[SelLsr] = 1'b1; dec_tbus = 1'b1; dec_rmw = 1'b1; dec_data = 1'b1;
                p_next[0] = operand_q[0];
            end
            8'h26: begin
                dec_sel[SelRol] = 1'b1; dec_cin = p_q[0]; dec_tbus = 1'b1; dec_rmw = 1'b1;
                dec_data = 1'b1; p_next[0] = operand_q[7];
            end
            8'h66: begin
                dec_sel[SelRor] = 1'b1; dec_cin = p_q[0]; dec_tbus = 1'b1; dec_rmw = 1'b1;
                dec_data = 1'b1; p_next[0] = operand_q[0];
            end
            8'h18:   p_next[0] = 1'b0;
            8'h38:   p_next[0] = 1'b1;
            8'hB8:   p_next[6] = 1'b0;
            default: dec_illegal = 1'b1;
        endcase
        if (dec_data) begin
            p_next[7] = alu_negative;
            p_next[1] = alu_zero;
        end
        p_next[5] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        a_d       = a_q;
        p_d       = p_q;
        wb_data_d = wb_data_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (op_valid) begin
                    opcode_d  = opcode;
                    operand_d = operand;
                    state_d   = StExec;
                end
            end
            StExec: begin
                if (dec_illegal) begin
                    done_d    = 1'b1;
                    illegal_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    p_d = p_next;
                    if (dec_write_a) a_d = alu_out;
                    if (dec_rmw) begin
                        wb_data_d = alu_out;
                        state_d   = StWb;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWb: begin
                if (wb_ready) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            opcode_q  <= 8'h00;
            operand_q <= 8'h00;
            a_q       <= 8'h00;
            p_q       <= P_RESET | 8'h20;
            wb_data_q <= 8'h00;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            a_q       <= a_d;
            p_q       <= p_d;
            wb_data_q <= wb_data_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign op_ready   = (state_q == StIdle);
    assign sum_sel    = exec & dec_sel[SelSum];
    assign and_sel    = exec & dec_sel[SelAnd];
    assign xor_sel    = exec & dec_sel[SelXor];
    assign or_sel     = exec & dec_sel[SelOr];
    assign asl_sel    = exec & dec_sel[SelAsl];
    assign lsr_sel    = exec & dec_sel[SelLsr];
    assign rol_sel    = exec & dec_sel[SelRol];
    assign ror_sel    = exec & dec_sel[SelRor];
    assign subtract   = exec & dec_sub;
    assign target_bus = exec & dec_tbus;
    assign carry_in   = exec & dec_cin;
    assign a_reg      = a_q;
    assign p_reg      = p_q;
    assign wb_valid   = (state_q == StWb);
    assign wb_data    = wb_data_q;
    assign done       = done_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU model, directed opcodes, scoreboard queues popped by
// a monitor on done / write-back handshakes.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [7:0] opcode = 8'h00;
    logic [7:0] operand = 8'h00;
    logic       sum_sel, and_sel, xor_sel, or_sel, asl_sel, lsr_sel, rol_sel, ror_sel;
    logic       subtract, target_bus, carry_in;
    logic [7:0] alu_out;
    logic       alu_overflow, alu_carry, alu_zero, alu_negative;
    logic [7:0] a_reg, p_reg;
    logic       wb_valid;
    logic [7:0] wb_data;
    logic       wb_ready = 1'b1;
    logic       done, illegal;

    typedef struct packed {
        logic       ill;
        logic [7:0] a;
        logic [7:0] p;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] wb_q[$];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.P_RESET(8'h20)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .operand(operand),
        .sum_sel(sum_sel), .and_sel(and_sel), .xor_sel(xor_sel), .or_sel(or_sel),
        .asl_sel(asl_sel), .lsr_sel(lsr_sel), .rol_sel(rol_sel), .ror_sel(ror_sel),
        .subtract(subtract), .target_bus(target_bus), .carry_in(carry_in),
        .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
        .alu_zero(alu_zero), .alu_negative(alu_negative),
        .a_reg(a_reg), .p_reg(p_reg), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_ready(wb_ready), .done(done), .illegal(illegal)
    );

    // Reference ALU: A and the operand bus feed it, target_bus picks the shift source.
    logic [7:0] m_b, m_src;
    logic [8:0] m_sum;
    always_comb begin
        m_b     = subtract ? ~operand : operand;
        m_src   = target_bus ? operand : a_reg;
        m_sum   = {1'b0, a_reg} + {1'b0, m_b} + {8'h00, carry_in};
        alu_out = 8'h00;
        if (sum_sel) alu_out = alu_out | m_sum[7:0];
        if (and_sel) alu_out = alu_out | (a_reg & operand);
        if (xor_sel) alu_out = alu_out | (a_reg ^ operand);
        if (or_sel)  alu_out = alu_out | (a_reg | operand);
        if (asl_sel) alu_out = alu_out | {m_src[6:0], 1'b0};
        if (lsr_sel) alu_out = alu_out | {1'b0, m_src[7:1]};
        if (rol_sel) alu_out = alu_out | {m_src[6:0], carry_in};
        if (ror_sel) alu_out = alu_out | {carry_in, m_src[7:1]};
        alu_overflow = (a_reg[7] == m_b[7]) && (m_sum[7] != a_reg[7]);
        alu_carry    = m_sum[8];
        alu_zero     = (alu_out == 8'h00);
        alu_negative = alu_out[7];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issues one op, pushes its expected retirement, and checks EXEC-cycle ALU controls.
    task automatic do_op(input logic [7:0] opc, input logic [7:0] opd, input logic [7:0] e_sel,
                         input logic [2:0] e_dfl, input logic e_ill, input logic [7:0] e_a,
                         input logic [7:0] e_p, input logic rmw, input logic [7:0] e_wb);
        int n = 0;
        @(negedge clk);
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            chk("op_ready_timeout", {31'd0, op_ready}, 32'd1);
            return;
        end
        exp_q.push_back('{ill: e_ill, a: e_a, p: e_p});
        if (rmw) wb_q.push_back(e_wb);
        op_valid = 1'b1;
        opcode   = opc;
        operand  = opd;
        @(posedge clk);
        #1 op_valid = 1'b0;
        chk("exec_sel", {24'd0, sum_sel, and_sel, xor_sel, or_sel, asl_sel, lsr_sel, rol_sel,
                         ror_sel}, {24'd0, e_sel});
        chk("exec_dataflow", {29'd0, subtract, target_bus, carry_in}, {29'd0, e_dfl});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_done", {31'd0, done}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_illegal", {31'd0, illegal}, {31'd0, e.ill});
                        chk("done_a_reg", {24'd0, a_reg}, {24'd0, e.a});
                        chk("done_p_reg", {24'd0, p_reg}, {24'd0, e.p});
                    end
                end
                if (wb_valid && wb_ready) begin
                    if (wb_q.size() == 0) chk("spurious_wb", {31'd0, wb_valid}, 32'd0);
                    else chk("wb_data", {24'd0, wb_data}, {24'd0, wb_q.pop_front()});
                end
            end
        end
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        chk("rst_a_reg", {24'd0, a_reg}, 32'h00);
        chk("rst_p_reg", {24'd0, p_reg}, 32'h20);
        chk("rst_flags", {28'd0, op_ready, wb_valid, done, illegal}, 32'b1000);
        chk("rst_sel", {21'd0, sum_sel, and_sel, xor_sel, or_sel, asl_sel, lsr_sel, rol_sel,
                        ror_sel, subtract, target_bus, carry_in}, 32'd0);
        chk("rst_wb_data", {24'd0, wb_data}, 32'h00);
        rst_n = 1'b1;

        //    opc    opd    sel    dfl    ill   a      p      rmw   wb
        do_op(8'h69, 8'h50, 8'h80, 3'b000, 1'b0, 8'h50, 8'h20, 1'b0, 8'h00);
        do_op(8'h69, 8'h50, 8'h80, 3'b000, 1'b0, 8'hA0, 8'hE0, 1'b0, 8'h00);
        do_op(8'h29, 8'h00, 8'h40, 3'b000, 1'b0, 8'h00, 8'h62, 1'b0, 8'h00);
        do_op(8'h38, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 8'h63, 1'b0, 8'h00);
        do_op(8'hE9, 8'h01, 8'h80, 3'b101, 1'b0, 8'hFF, 8'hA0, 1'b0, 8'h00);
        do_op(8'h29, 8'h00, 8'h40, 3'b000, 1'b0, 8'h00, 8'h22, 1'b0, 8'h00);
        do_op(8'h09, 8'h40, 8'h10, 3'b000, 1'b0, 8'h40, 8'h20, 1'b0, 8'h00);
        do_op(8'h69, 8'h40, 8'h80, 3'b000, 1'b0, 8'h80, 8'hE0, 1'b0, 8'h00);
        do_op(8'h49, 8'hC0, 8'h20, 3'b000, 1'b0, 8'h40, 8'h60, 1'b0, 8'h00);
        do_op(8'hC9, 8'h40, 8'h80, 3'b101, 1'b0, 8'h40, 8'h63, 1'b0, 8'h00);

        // ROL mem with the write-back stalled.
        wb_ready = 1'b0;
        do_op(8'h26, 8'h80, 8'h02, 3'b011, 1'b0, 8'h40, 8'h61, 1'b1, 8'h01);
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("stall_wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("stall_wb_data", {24'd0, wb_data}, 32'h01);
            chk("stall_ready_done", {30'd0, op_ready, done}, 32'd0);
        end
        @(posedge clk);
        #1 wb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wb_release_done", {30'd0, done, op_ready}, 32'b11);

        do_op(8'h0A, 8'h00, 8'h08, 3'b000, 1'b0, 8'h80, 8'hE0, 1'b0, 8'h00);
        do_op(8'h46, 8'h01, 8'h04, 3'b010, 1'b0, 8'h80, 8'h63, 1'b1, 8'h00);
        do_op(8'h6A, 8'h00, 8'h01, 3'b001, 1'b0, 8'hC0, 8'hE0, 1'b0, 8'h00);
        do_op(8'hB8, 8'h00, 8'h00, 3'b000, 1'b0, 8'hC0, 8'hA0, 1'b0, 8'h00);
        do_op(8'h18, 8'h00, 8'h00, 3'b000, 1'b0, 8'hC0, 8'hA0, 1'b0, 8'h00);
        do_op(8'hFF, 8'h12, 8'h00, 3'b000, 1'b1, 8'hC0, 8'hA0, 1'b0, 8'h00);
        do_op(8'h38, 8'h00, 8'h00, 3'b000, 1'b0, 8'hC0, 8'hA1, 1'b0, 8'h00);

        // Reset while a write-back is pending drops the op.
        wb_ready = 1'b0;
        do_op(8'h06, 8'h81, 8'h08, 3'b010, 1'b0, 8'hC0, 8'hA1, 1'b1, 8'h02);
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_wb_valid", {31'd0, wb_valid}, 32'd1);
        #1 rst_n = 1'b0;
        exp_q.delete();
        wb_q.delete();
        #1;
        chk("async_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("async_rst_a_reg", {24'd0, a_reg}, 32'h00);
        chk("async_rst_p_reg", {24'd0, p_reg}, 32'h20);
        @(negedge clk);
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_op_ready", {31'd0, op_ready}, 32'd1);

        do_op(8'h69, 8'h01, 8'h80, 3'b000, 1'b0, 8'h01, 8'h20, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        chk("queues_drained", exp_q.size() + wb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
